alu_arbiter: RTL and testbench

//  Shares one combinational RV32 ALU (op[2:0]/alt encoding: ADD/SUB, SLL, SLT,

---
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational RV32 ALU.
// Ports: clk/rst, req0_*/rsp0_*, req1_*/rsp1_* valid/ready pairs, alu_* to/from ALU.
module alu_arbiter #(
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic              req0_alt,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_res,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic              req1_alt,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_res,
  output logic [DATA_W-1:0] alu_src_a,
  output logic [DATA_W-1:0] alu_src_b,
  output logic [2:0]        alu_op,
  output logic              alu_alt,
  input  logic [DATA_W-1:0] alu_res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic              owner;
  logic              last_grant;
  logic [DATA_W-1:0] result;
  logic              win;
  logic              accept;
  logic              rsp_hs;

  // win = 1 selects requester 1; on a tie round-robin favours
  // whoever was not granted last.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FIXED_PRIO != 0) win = 1'b0;
      else                 win = ~last_grant;
    end else begin
      win = req1_valid;
    end
  end

  // rst gating keeps ready low while reset is held.
  assign accept = (state == S_IDLE) && !rst &&
                  (req0_valid || req1_valid);

  assign req0_ready = accept && !win;
  assign req1_ready = accept && win;

  assign rsp0_valid = (state == S_RESP) && !owner;
  assign rsp1_valid = (state == S_RESP) && owner;
  assign rsp0_res   = result;
  assign rsp1_res   = result;

  assign rsp_hs = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      result     <= '0;
      alu_src_a  <= '0;
      alu_src_b  <= '0;
      alu_op     <= 3'd0;
      alu_alt    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner      <= win;
            last_grant <= win;
            alu_src_a  <= win ? req1_a   : req0_a;
            alu_src_b  <= win ? req1_b   : req0_b;
            alu_op     <= win ? req1_op  : req0_op;
            alu_alt    <= win ? req1_alt : req0_alt;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          result <= alu_res;
          state  <= S_RESP;
        end
        S_RESP: begin
          if (rsp_hs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of ALU ops per requester,
// plus arbitration, back-pressure, payload-hold and reset sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 0, req1_op = 0;
  logic        req0_alt = 0, req1_alt = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1, rsp1_ready = 1;
  logic [31:0] rsp0_res, rsp1_res;
  logic [31:0] alu_src_a, alu_src_b, alu_res;
  logic [2:0]  alu_op;
  logic        alu_alt;

  logic        f_req0_valid = 0, f_req1_valid = 0;
  logic        f_req0_ready, f_req1_ready;
  logic        f_rsp0_valid, f_rsp1_valid;
  logic [31:0] f_rsp0_res, f_rsp1_res;
  logic [31:0] f_alu_src_a, f_alu_src_b, f_alu_res;
  logic [2:0]  f_alu_op;
  logic        f_alu_alt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(
    input logic [2:0] op, input logic alt,
    input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (op)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = {31'd0, $signed(a) < $signed(b)};
      3'd3: r = {31'd0, a < b};
      3'd4: r = a ^ b;
      3'd5: begin
        if (alt) r = $signed(a) >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign alu_res   = alu_f(alu_op, alu_alt, alu_src_a, alu_src_b);
  assign f_alu_res = alu_f(f_alu_op, f_alu_alt, f_alu_src_a, f_alu_src_b);

  alu_arbiter #(.DATA_W(32), .FIXED_PRIO(0)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_alt(req0_alt),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_res(rsp0_res),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_alt(req1_alt),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_res(rsp1_res),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .alu_alt(alu_alt), .alu_res(alu_res)
  );

  alu_arbiter #(.DATA_W(32), .FIXED_PRIO(1)) u_fix (
    .clk(clk), .rst(rst),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready),
    .req0_op(req0_op), .req0_alt(req0_alt),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(1'b1),
    .rsp0_res(f_rsp0_res),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready),
    .req1_op(req1_op), .req1_alt(req1_alt),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(1'b1),
    .rsp1_res(f_rsp1_res),
    .alu_src_a(f_alu_src_a), .alu_src_b(f_alu_src_b),
    .alu_op(f_alu_op), .alu_alt(f_alu_alt), .alu_res(f_alu_res)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " req_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    chk({tag, " rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk({tag, " rsp0_res"}, rsp0_res, 32'd0);
    chk({tag, " rsp1_res"}, rsp1_res, 32'd0);
    chk({tag, " alu_src_a"}, alu_src_a, 32'd0);
    chk({tag, " alu_src_b"}, alu_src_b, 32'd0);
    chk({tag, " alu_op"}, {29'd0, alu_op}, 32'd0);
    chk({tag, " alu_alt"}, {31'd0, alu_alt}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        who;
    logic [2:0]  op;
    logic        alt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 3'd0, 1'b0, 32'd5, 32'd7, 32'd12};
    vecs[1] = '{1'b1, 3'd0, 1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE};
    vecs[2] = '{1'b1, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000};
    vecs[3] = '{1'b0, 3'd5, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000};
    vecs[4] = '{1'b0, 3'd1, 1'b0, 32'd1, 32'd31, 32'h8000_0000};
    vecs[5] = '{1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1};
    vecs[6] = '{1'b0, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0};
    vecs[7] = '{1'b1, 3'd4, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00,
                32'h0FF0_0FF0};
    vecs[8] = '{1'b0, 3'd6, 1'b0, 32'h0000_000F, 32'h0000_00F0,
                32'h0000_00FF};
    vecs[9] = '{1'b1, 3'd7, 1'b0, 32'hFFFF_0000, 32'h1234_5678,
                32'h1234_0000};

    // reset state
    @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // table: one requester at a time
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      if (vecs[i].who) begin
        req1_valid = 1'b1; req1_op = vecs[i].op; req1_alt = vecs[i].alt;
        req1_a = vecs[i].a; req1_b = vecs[i].b;
      end else begin
        req0_valid = 1'b1; req0_op = vecs[i].op; req0_alt = vecs[i].alt;
        req0_a = vecs[i].a; req0_b = vecs[i].b;
      end
      #1;
      chk($sformatf("v%0d ready", i), {30'd0, req1_ready, req0_ready},
          vecs[i].who ? 32'd2 : 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk($sformatf("v%0d exec ready", i),
          {30'd0, req1_ready, req0_ready}, 32'd0);
      chk($sformatf("v%0d alu_op", i), {28'd0, alu_alt, alu_op},
          {28'd0, vecs[i].alt, vecs[i].op});
      chk($sformatf("v%0d alu_src_a", i), alu_src_a, vecs[i].a);
      chk($sformatf("v%0d exec rsp", i),
          {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d rsp_valid", i), {30'd0, rsp1_valid, rsp0_valid},
          vecs[i].who ? 32'd2 : 32'd1);
      chk($sformatf("v%0d res", i), vecs[i].who ? rsp1_res : rsp0_res,
          vecs[i].res);
    end

    // continuous contention: round-robin vs fixed priority
    do_reset();
    for (int c = 0; c < 12; c++) begin
      logic [1:0] e_rdy, e_rsp, f_rdy, f_rsp;
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 3'd0; req0_alt = 1'b0;
      req0_a = 32'd1; req0_b = 32'd2;
      req1_valid = 1'b1; req1_op = 3'd0; req1_alt = 1'b0;
      req1_a = 32'd3; req1_b = 32'd4;
      f_req0_valid = 1'b1;
      f_req1_valid = 1'b1;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      #1;
      e_rdy = 2'b00; e_rsp = 2'b00; f_rdy = 2'b00; f_rsp = 2'b00;
      if (c % 3 == 0) begin
        e_rdy = ((c / 3) % 2 == 1) ? 2'b10 : 2'b01;
        f_rdy = 2'b01;
      end
      if (c % 3 == 2) begin
        e_rsp = (((c - 2) / 3) % 2 == 1) ? 2'b10 : 2'b01;
        f_rsp = 2'b01;
      end
      chk($sformatf("rr c%0d ready", c), {30'd0, req1_ready, req0_ready},
          {30'd0, e_rdy});
      chk($sformatf("rr c%0d rsp", c), {30'd0, rsp1_valid, rsp0_valid},
          {30'd0, e_rsp});
      if (c % 3 == 2)
        chk($sformatf("rr c%0d res", c), e_rsp[1] ? rsp1_res : rsp0_res,
            e_rsp[1] ? 32'd7 : 32'd3);
      chk($sformatf("fix c%0d ready", c),
          {30'd0, f_req1_ready, f_req0_ready}, {30'd0, f_rdy});
      chk($sformatf("fix c%0d rsp", c),
          {30'd0, f_rsp1_valid, f_rsp0_valid}, {30'd0, f_rsp});
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;

    // back-pressure on rsp0 with req1 waiting and changing payload
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd0; req0_alt = 1'b0;
    req0_a = 32'd10; req0_b = 32'd20;
    req1_valid = 1'b1; req1_op = 3'd0; req1_alt = 1'b0;
    req1_a = 32'd1; req1_b = 32'd1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    #1;
    chk("bp accept0", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("bp exec ready1", {31'd0, req1_ready}, 32'd0);
    for (int c = 2; c < 7; c++) begin
      @(negedge clk);
      if (c == 4) req1_a = 32'd100;
      #1;
      chk($sformatf("bp c%0d rsp0_valid", c), {31'd0, rsp0_valid}, 32'd1);
      chk($sformatf("bp c%0d rsp0_res", c), rsp0_res, 32'd30);
      chk($sformatf("bp c%0d ready1", c), {31'd0, req1_ready}, 32'd0);
      chk($sformatf("bp c%0d rsp1", c), {31'd0, rsp1_valid}, 32'd0);
    end
    @(negedge clk);
    rsp0_ready = 1'b1;
    #1;
    chk("bp hs rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    chk("bp accept1", {30'd0, req1_ready, req0_ready}, 32'd2);
    chk("bp rsp0 gone", {31'd0, rsp0_valid}, 32'd0);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("bp rsp1_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
    chk("bp rsp1_res", rsp1_res, 32'd101);
    @(negedge clk);
    rsp0_ready = 1'b1;

    // reset during EXEC
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd5; req0_alt = 1'b1;
    req0_a = 32'h8000_0000; req0_b = 32'd4;
    #1;
    chk("rx accept", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("rx exec op", {28'd0, alu_alt, alu_op}, 32'hD);
    rst = 1'b1;
    #1;
    chk_idle_outputs("rx");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rx post c%0d rsp", c),
          {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end

    // reset during RESP
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd4; req0_alt = 1'b0;
    req0_a = 32'hF; req0_b = 32'h3;
    rsp0_ready = 1'b0;
    #1;
    chk("rr2 accept", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rr2 rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("rr2 rsp0_res", rsp0_res, 32'hC);
    rst = 1'b1;
    #1;
    chk_idle_outputs("rr2");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rr2 post c%0d rsp", c),
          {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end

    // tie after reset goes to req0 even though req0 was granted last
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp0_ready = 1'b1;
    #1;
    chk("post reset tie", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
